// File: rtl/orion_reset_cfg_seq.sv
// Front end for orion_pro_top: synchronises and debounces the DIP switches and reset button,
// sequences core reset release (settle -> hold -> run) and generates the CPU clock-enable strobe.
module orion_reset_cfg_seq #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1024,
  parameter int unsigned RESET_HOLD_CYCLES = 64,
  parameter int unsigned DIV_NORMAL        = 8,
  parameter int unsigned DIV_TURBO         = 4,
  parameter logic        TURBO_CLK_10      = 1'b1,
  parameter int unsigned TURBO_SW_BIT      = 3,
  parameter logic [7:0]  RESET_MASK        = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_cfg_sw,
  input  logic       i_reset_btn,
  output logic [7:0] o_cfg_sw,
  output logic       o_reset_n,
  output logic       o_cpu_ce,
  output logic       o_cfg_changed,
  output logic       o_ready
);

  localparam int unsigned DBW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW      = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam int unsigned DIV_MAX = (DIV_NORMAL > DIV_TURBO) ? DIV_NORMAL : DIV_TURBO;
  localparam int unsigned DCW     = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST  = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [DCW-1:0] DIV_N_LAST = DCW'(DIV_NORMAL - 1);
  localparam logic [DCW-1:0] DIV_T_LAST = DCW'(DIV_TURBO - 1);
  localparam logic [2:0]     TSB        = 3'(TURBO_SW_BIT);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  logic [7:0]     sw_meta;
  logic [7:0]     sw_sync;
  logic           btn_meta;
  logic           btn_sync;

  logic [7:0]     sw_cand;
  logic [DBW-1:0] sw_cnt;
  logic           sw_settled;

  logic           btn_cand;
  logic [DBW-1:0] btn_cnt;
  logic           btn_db;
  logic           btn_db_prev;

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_nxt;

  logic [7:0]     cfg_q;
  logic           cfg_chg_q;
  logic           rst_n_q;

  logic           settle_load;
  logic           sw_accept;
  logic           cfg_trig;
  logic           press;
  logic           retrig;

  logic           run_div;
  logic           ce;
  logic [DCW-1:0] div_cnt;
  logic [DCW-1:0] div_last;

  function automatic logic [DCW-1:0] div_last_for(input logic [7:0] sw);
    if (TURBO_CLK_10 && sw[TSB]) begin
      return DIV_T_LAST;
    end
    return DIV_N_LAST;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_meta  <= i_cfg_sw;
      sw_sync  <= sw_meta;
      btn_meta <= i_reset_btn;
      btn_sync <= btn_meta;
    end
  end

  assign sw_settled = (sw_cnt == DB_LAST);

  // One counter covers the whole vector: any bit moving restarts the stability window.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_cand <= '0;
      sw_cnt  <= '0;
    end else if (sw_sync != sw_cand) begin
      sw_cand <= sw_sync;
      sw_cnt  <= '0;
    end else if (!sw_settled) begin
      sw_cnt  <= sw_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      btn_cand    <= 1'b0;
      btn_cnt     <= '0;
      btn_db      <= 1'b0;
      btn_db_prev <= 1'b0;
    end else begin
      btn_db_prev <= btn_db;
      if (btn_cnt == DB_LAST) begin
        btn_db <= btn_cand;
      end
      if (btn_sync != btn_cand) begin
        btn_cand <= btn_sync;
        btn_cnt  <= '0;
      end else if (btn_cnt != DB_LAST) begin
        btn_cnt  <= btn_cnt + 1'b1;
      end
    end
  end

  assign settle_load = (state == ST_SETTLE) && sw_settled;
  assign sw_accept   = (state != ST_SETTLE) && sw_settled && (sw_cand != cfg_q);
  assign cfg_trig    = sw_accept && (((sw_cand ^ cfg_q) & RESET_MASK) != 8'h00);
  assign press       = btn_db && !btn_db_prev;
  assign retrig      = press || cfg_trig;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      ST_SETTLE: begin
        if (sw_settled) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
        end
      end
      ST_HOLD: begin
        if (retrig) begin
          hold_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (retrig) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_SETTLE;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_SETTLE;
      hold_cnt <= '0;
      rst_n_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      rst_n_q  <= (state_nxt == ST_RUN);
    end
  end

  // The first accepted vector after reset is loaded silently; later ones pulse o_cfg_changed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cfg_q     <= '0;
      cfg_chg_q <= 1'b0;
    end else begin
      cfg_chg_q <= sw_accept;
      if (settle_load || sw_accept) begin
        cfg_q <= sw_cand;
      end
    end
  end

  assign run_div = (state != ST_SETTLE);
  assign ce      = run_div && (div_cnt == div_last);

  // The period is re-selected only at wrap so a mode change never truncates a period; while
  // settling it tracks the candidate so the first period already matches the loaded vector.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_cnt  <= '0;
      div_last <= DIV_N_LAST;
    end else if (!run_div) begin
      div_cnt  <= '0;
      div_last <= div_last_for(sw_cand);
    end else if (ce) begin
      div_cnt  <= '0;
      div_last <= div_last_for(cfg_q);
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  assign o_cfg_sw      = cfg_q;
  assign o_cfg_changed = cfg_chg_q;
  assign o_reset_n     = rst_n_q;
  assign o_ready       = rst_n_q;
  assign o_cpu_ce      = ce;

endmodule

// File: tb/tb_orion_reset_cfg_seq.sv
// Bench for orion_reset_cfg_seq: two instances (reset mask FF and 01) share stimulus and are
// compared every cycle against a behavioural reference, plus scenario-level timing checks.
module tb_orion_reset_cfg_seq;

  localparam int DB = 8;
  localparam int RH = 4;
  localparam int DN = 8;
  localparam int DT = 4;
  localparam logic [7:0] MASK0 = 8'hFF;
  localparam logic [7:0] MASK1 = 8'h01;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_cfg_sw = 8'h00;
  logic       i_reset_btn = 1'b0;

  logic [7:0] cfg_sw [2];
  logic       rstn [2];
  logic       ce [2];
  logic       chg [2];
  logic       rdy [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  orion_reset_cfg_seq #(
    .DEBOUNCE_CYCLES(DB), .RESET_HOLD_CYCLES(RH), .DIV_NORMAL(DN), .DIV_TURBO(DT),
    .TURBO_CLK_10(1'b1), .TURBO_SW_BIT(3), .RESET_MASK(MASK0)
  ) dut0 (
    .i_clk(clk), .i_reset(i_reset), .i_cfg_sw(i_cfg_sw), .i_reset_btn(i_reset_btn),
    .o_cfg_sw(cfg_sw[0]), .o_reset_n(rstn[0]), .o_cpu_ce(ce[0]),
    .o_cfg_changed(chg[0]), .o_ready(rdy[0])
  );

  orion_reset_cfg_seq #(
    .DEBOUNCE_CYCLES(DB), .RESET_HOLD_CYCLES(RH), .DIV_NORMAL(DN), .DIV_TURBO(DT),
    .TURBO_CLK_10(1'b1), .TURBO_SW_BIT(3), .RESET_MASK(MASK1)
  ) dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_cfg_sw(i_cfg_sw), .i_reset_btn(i_reset_btn),
    .o_cfg_sw(cfg_sw[1]), .o_reset_n(rstn[1]), .o_cpu_ce(ce[1]),
    .o_cfg_changed(chg[1]), .o_ready(rdy[1])
  );

  // Reference: a switch value/button level is "taken" once it has been seen for DB cycles
  // after the two-cycle synchroniser; phases 0/1/2 = settle/hold/run, hold counts down.
  logic [7:0] r_s1, r_s2, sw_val, m_cfg;
  int         sw_age;
  logic       r_b1, r_b2, bt_val, bt_lvl, bt_prev;
  int         bt_age;
  logic       m_chg;
  int         ph [2];
  int         left [2];
  int         since [2];
  int         per [2];
  logic       rn [2];

  function automatic int div_of(input logic [7:0] v);
    return v[3] ? DT : DN;
  endfunction

  function automatic logic m_ce(input int k);
    return (ph[k] != 0) && (since[k] == per[k] - 1);
  endfunction

  function automatic logic [11:0] expv(input int k);
    return {m_cfg, rn[k], m_ce(k), m_chg, rn[k]};
  endfunction

  function automatic logic [11:0] obsv(input int k);
    return {cfg_sw[k], rstn[k], ce[k], chg[k], rdy[k]};
  endfunction

  always @(posedge clk) begin : ref_model
    logic sw_ok, bt_ok, press, take, trig;
    int   nph, nleft;
    if (i_reset) begin
      r_s1 <= '0; r_s2 <= '0; sw_val <= '0; m_cfg <= '0; sw_age <= 0;
      r_b1 <= 1'b0; r_b2 <= 1'b0; bt_val <= 1'b0; bt_lvl <= 1'b0; bt_prev <= 1'b0; bt_age <= 0;
      m_chg <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        ph[k] <= 0; left[k] <= 0; since[k] <= 0; per[k] <= DN; rn[k] <= 1'b0;
      end
    end else begin
      sw_ok = (sw_age >= DB - 1);
      bt_ok = (bt_age >= DB - 1);
      press = bt_lvl && !bt_prev;
      take  = (ph[0] != 0) && sw_ok && (sw_val != m_cfg);
      for (int k = 0; k < 2; k++) begin
        trig  = press || (take && (((sw_val ^ m_cfg) & ((k == 0) ? MASK0 : MASK1)) != 8'h00));
        nph   = ph[k];
        nleft = left[k];
        if (ph[k] == 0) begin
          since[k] <= 0;
          per[k]   <= div_of(sw_val);
          if (sw_ok) begin nph = 1; nleft = RH; end
        end else begin
          if (since[k] == per[k] - 1) begin
            since[k] <= 0;
            per[k]   <= div_of(m_cfg);
          end else begin
            since[k] <= since[k] + 1;
          end
          if (trig) begin
            nph = 1; nleft = RH;
          end else if (ph[k] == 1) begin
            if (left[k] == 1) nph = 2;
            else nleft = left[k] - 1;
          end
        end
        ph[k]   <= nph;
        left[k] <= nleft;
        rn[k]   <= (nph == 2);
      end
      m_chg <= take;
      if (take || ((ph[0] == 0) && sw_ok)) m_cfg <= sw_val;
      if (r_s2 != sw_val) begin sw_val <= r_s2; sw_age <= 0; end
      else sw_age <= sw_age + 1;
      bt_prev <= bt_lvl;
      if (bt_ok) bt_lvl <= bt_val;
      if (r_b2 != bt_val) begin bt_val <= r_b2; bt_age <= 0; end
      else bt_age <= bt_age + 1;
      r_s2 <= r_s1; r_s1 <= i_cfg_sw;
      r_b2 <= r_b1; r_b1 <= i_reset_btn;
    end
  end

  task automatic test_reset();
    i_reset  = 1'b1;
    i_cfg_sw = 8'h0F;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== 12'h000) begin
          errors++;
          $display("FAIL reset_outputs dut%0d got=%h want=000", k, obsv(k));
        end
      end
    end
  endtask

  task automatic test_power_up();
    int waited = 0; int chg_cnt = 0; int hold_cyc = 0; int last_ce = -1;
    i_reset = 1'b0;
    while (rstn[0] !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          errors++;
          $display("FAIL powerup_model dut%0d t=%0t got=%h want=%h", k, $time, obsv(k), expv(k));
        end
      end
      if (chg[0] === 1'b1) chg_cnt++;
      if (cfg_sw[0] === 8'h0F && rstn[0] === 1'b0) hold_cyc++;
    end
    checks++;
    if (rstn[0] !== 1'b1) begin errors++; $display("FAIL powerup_timeout got=%b want=1", rstn[0]); end
    checks++;
    if (cfg_sw[0] !== 8'h0F) begin errors++; $display("FAIL powerup_cfg got=%h want=0f", cfg_sw[0]); end
    checks++;
    if (chg_cnt != 0) begin errors++; $display("FAIL powerup_no_changed got=%0d want=0", chg_cnt); end
    checks++;
    if (hold_cyc != RH) begin errors++; $display("FAIL powerup_hold_len got=%0d want=%0d", hold_cyc, RH); end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          errors++;
          $display("FAIL powerup_ce_model dut%0d t=%0t got=%h want=%h", k, $time, obsv(k), expv(k));
        end
      end
      if (ce[0] === 1'b1) begin
        if (last_ce >= 0) begin
          checks++;
          if (c - last_ce != DT) begin
            errors++; $display("FAIL turbo_period got=%0d want=%0d", c - last_ce, DT);
          end
        end
        last_ce = c;
      end
    end
  endtask

  task automatic test_glitch();
    int chg_cnt = 0; int low_cnt = 0; int len; logic [7:0] flip;
    for (int rep = 0; rep < 3; rep++) begin
      len  = (rep == 0) ? 5 : int'($urandom_range(1, DB - 3));
      flip = (rep == 0) ? 8'h01 : 8'($urandom_range(1, 255));
      for (int c = 0; c < len + 20; c++) begin
        i_cfg_sw = (c < len) ? (8'h0F ^ flip) : 8'h0F;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (obsv(k) !== expv(k)) begin
            errors++;
            $display("FAIL glitch_model dut%0d t=%0t got=%h want=%h", k, $time, obsv(k), expv(k));
          end
        end
        if (chg[0] === 1'b1) chg_cnt++;
        if (rstn[0] !== 1'b1) low_cnt++;
      end
    end
    checks++;
    if (cfg_sw[0] !== 8'h0F) begin errors++; $display("FAIL glitch_cfg got=%h want=0f", cfg_sw[0]); end
    checks++;
    if (chg_cnt != 0) begin errors++; $display("FAIL glitch_changed got=%0d want=0", chg_cnt); end
    checks++;
    if (low_cnt != 0) begin errors++; $display("FAIL glitch_reset got=%0d want=0", low_cnt); end
  endtask

  task automatic test_accept_change();
    int chg0 = 0; int chg1 = 0; int low0 = 0; int low1 = 0; int last_ce = -1;
    i_cfg_sw = 8'h07;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          errors++;
          $display("FAIL accept_model dut%0d t=%0t got=%h want=%h", k, $time, obsv(k), expv(k));
        end
      end
      if (chg[0] === 1'b1) chg0++;
      if (chg[1] === 1'b1) chg1++;
      if (rstn[0] !== 1'b1) low0++;
      if (rstn[1] !== 1'b1) low1++;
    end
    checks++;
    if (cfg_sw[0] !== 8'h07) begin errors++; $display("FAIL accept_cfg got=%h want=07", cfg_sw[0]); end
    checks++;
    if (chg0 != 1 || chg1 != 1) begin
      errors++; $display("FAIL accept_changed got=%0d/%0d want=1/1", chg0, chg1);
    end
    checks++;
    if (low0 != RH) begin errors++; $display("FAIL accept_hold_len got=%0d want=%0d", low0, RH); end
    checks++;
    if (low1 != 0) begin errors++; $display("FAIL accept_masked_hold got=%0d want=0", low1); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          errors++;
          $display("FAIL normal_ce_model dut%0d t=%0t got=%h want=%h", k, $time, obsv(k), expv(k));
        end
      end
      if (ce[0] === 1'b1) begin
        if (last_ce >= 0) begin
          checks++;
          if (c - last_ce != DN) begin
            errors++; $display("FAIL normal_period got=%0d want=%0d", c - last_ce, DN);
          end
        end
        last_ce = c;
      end
    end
  endtask

  task automatic test_masked_change();
    int chg1 = 0; int low0 = 0; int low1 = 0; int hold_for;
    i_cfg_sw = 8'h87;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          errors++;
          $display("FAIL masked_model dut%0d t=%0t got=%h want=%h", k, $time, obsv(k), expv(k));
        end
      end
      if (chg[1] === 1'b1) chg1++;
      if (rstn[0] !== 1'b1) low0++;
      if (rstn[1] !== 1'b1) low1++;
    end
    checks++;
    if (cfg_sw[1] !== 8'h87) begin errors++; $display("FAIL masked_cfg got=%h want=87", cfg_sw[1]); end
    checks++;
    if (chg1 != 1) begin errors++; $display("FAIL masked_changed got=%0d want=1", chg1); end
    checks++;
    if (low1 != 0) begin errors++; $display("FAIL masked_no_reset got=%0d want=0", low1); end
    checks++;
    if (low0 != RH) begin errors++; $display("FAIL unmasked_hold_len got=%0d want=%0d", low0, RH); end
    for (int rep = 0; rep < 7; rep++) begin
      i_cfg_sw = (rep == 6) ? 8'h07 : 8'($urandom);
      hold_for = (rep == 6) ? 40 : int'($urandom_range(1, 16));
      for (int c = 0; c < hold_for; c++) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (obsv(k) !== expv(k)) begin
            errors++;
            $display("FAIL random_cfg_model dut%0d t=%0t got=%h want=%h", k, $time, obsv(k), expv(k));
          end
        end
      end
    end
  endtask

  task automatic test_button();
    int low0; int falls0; int falls1; int chg0; int koff; logic prev0; logic prev1;
    for (int rep = 0; rep < 3; rep++) begin
      koff = (rep == 0) ? 0 : ((rep == 1) ? 1 : int'($urandom_range(2, 3)));
      low0 = 0; falls0 = 0; falls1 = 0; chg0 = 0; prev0 = rstn[0]; prev1 = rstn[1];
      for (int c = 0; c < 50; c++) begin
        i_reset_btn = (c < 20);
        if (koff != 0 && c == koff) i_cfg_sw = i_cfg_sw ^ 8'h01;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (obsv(k) !== expv(k)) begin
            errors++;
            $display("FAIL button_model dut%0d t=%0t got=%h want=%h", k, $time, obsv(k), expv(k));
          end
        end
        if (rstn[0] !== 1'b1) low0++;
        if (prev0 === 1'b1 && rstn[0] === 1'b0) falls0++;
        if (prev1 === 1'b1 && rstn[1] === 1'b0) falls1++;
        if (chg[0] === 1'b1) chg0++;
        prev0 = rstn[0];
        prev1 = rstn[1];
      end
      checks++;
      if (falls0 != 1 || falls1 != 1) begin
        errors++; $display("FAIL button_single_hold k=%0d got=%0d/%0d want=1/1", koff, falls0, falls1);
      end
      checks++;
      if (chg0 != ((koff != 0) ? 1 : 0)) begin
        errors++; $display("FAIL button_changed k=%0d got=%0d want=%0d", koff, chg0, (koff != 0) ? 1 : 0);
      end
      checks++;
      if (low0 < RH || low0 > RH + koff) begin
        errors++; $display("FAIL button_low_len k=%0d got=%0d want=%0d..%0d", koff, low0, RH, RH + koff);
      end
    end
  endtask

  task automatic test_mid_reset();
    int waited = 0; int chg_cnt = 0; logic [7:0] want_cfg;
    want_cfg = i_cfg_sw;
    checks++;
    if (rstn[0] !== 1'b1) begin errors++; $display("FAIL midreset_precond got=%b want=1", rstn[0]); end
    i_reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obsv(k) !== 12'h000) begin
        errors++; $display("FAIL midreset_outputs dut%0d got=%h want=000", k, obsv(k));
      end
    end
    @(negedge clk);
    i_reset = 1'b0;
    while (rstn[0] !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obsv(k) !== expv(k)) begin
          errors++;
          $display("FAIL midreset_model dut%0d t=%0t got=%h want=%h", k, $time, obsv(k), expv(k));
        end
      end
      if (chg[0] === 1'b1) chg_cnt++;
    end
    checks++;
    if (rstn[0] !== 1'b1) begin errors++; $display("FAIL midreset_timeout got=%b want=1", rstn[0]); end
    checks++;
    if (cfg_sw[0] !== want_cfg) begin
      errors++; $display("FAIL midreset_cfg got=%h want=%h", cfg_sw[0], want_cfg);
    end
    checks++;
    if (chg_cnt != 0) begin errors++; $display("FAIL midreset_changed got=%0d want=0", chg_cnt); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_accept_change();
    test_masked_change();
    test_button();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/orion_reset_cfg_seq.md
Name: orion_reset_cfg_seq

Overview:
- Front-end conditioning stage directly upstream of orion_pro_top. Drives the core's i_reset_n and i_cfg_sw.
- Synchronises and debounces the raw configuration DIP switches and the reset push-button.
- Sequences reset release: settle, then hold, then run.
- Generates the CPU clock-enable strobe, whose rate (normal or turbo) is selected by a switch.

Parameters:
- DEBOUNCE_CYCLES, 1024: consecutive stable i_clk cycles needed before a switch vector or button level is accepted (>=2).
- RESET_HOLD_CYCLES, 64: number of cycles o_reset_n is held low after settle or re-trigger (>=1).
- DIV_NORMAL, 8: i_clk cycles per o_cpu_ce pulse in normal mode (>=2).
- DIV_TURBO, 4: i_clk cycles per o_cpu_ce pulse in turbo mode (>=2).
- TURBO_CLK_10, 1'b1: turbo mode allowed; when 0, the divider is always DIV_NORMAL.
- TURBO_SW_BIT, 3: index of the switch selecting turbo (1 = turbo).
- RESET_MASK, 8'hFF: switch bits whose accepted change forces a core reset.

Ports:
- i_clk, in, 1: system clock.
- i_reset, in, 1: synchronous, active-high reset.
- i_cfg_sw, in, 8: raw asynchronous DIP switches.
- i_reset_btn, in, 1: raw asynchronous button, active-high.
- o_cfg_sw, out, 8: debounced, accepted switch vector to the core.
- o_reset_n, out, 1: core reset, active-low.
- o_cpu_ce, out, 1: single-cycle CPU clock-enable pulse.
- o_cfg_changed, out, 1: one-cycle pulse when o_cfg_sw updates.
- o_ready, out, 1: high in RUN state.

Behaviour:
- Synchronisation: a 2-flop synchroniser on each switch bit and on the button. All logic below uses the synchronised values, so inputs have 2 cycles of latency.
- Switch debounce (one shared counter over the whole vector):
  - If the synced vector differs from the candidate: candidate <= synced, counter <= 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - When the counter reaches DEBOUNCE_CYCLES-1 and candidate != o_cfg_sw: o_cfg_sw <= candidate next cycle, and o_cfg_changed pulses for exactly 1 cycle.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches o_cfg_sw.
- Button debounce: a separate counter with the same rule producing btn_db. A press event is a 0->1 edge of btn_db.
- FSM:
  - SETTLE (after reset): waits for the first moment the switch counter reaches DEBOUNCE_CYCLES-1. o_cfg_sw is loaded with the candidate unconditionally, with no o_cfg_changed pulse. Then go to HOLD.
  - HOLD: hold counter counts 0..RESET_HOLD_CYCLES-1, then go to RUN.
  - RUN: a press event, or an accepted o_cfg_sw change where (old ^ new) & RESET_MASK != 0, moves to HOLD with the hold counter cleared.
  - Re-trigger while in HOLD: the same events clear the hold counter, which restarts the hold.
  - A press held continuously does not retrigger. Only the edge counts.
- o_reset_n = 1 only in RUN (registered). o_ready equals o_reset_n.
- Clock enable:
  - Divider counter runs in HOLD and RUN and is held at 0 in SETTLE.
  - o_cpu_ce = 1 in the cycle the counter equals DIV-1, and the counter then wraps to 0.
  - DIV = DIV_TURBO if TURBO_CLK_10 && o_cfg_sw[TURBO_SW_BIT], else DIV_NORMAL.
  - A DIV change is sampled only at wrap, so the period is never truncated and never shorter than min(DIV_NORMAL, DIV_TURBO).
- Reset values on i_reset: state SETTLE; o_cfg_sw = 8'h00, o_reset_n = 0, o_cpu_ce = 0, o_cfg_changed = 0, o_ready = 0. All counters, synchronisers, candidate and btn_db are cleared to 0. An i_reset asserted mid-HOLD or mid-RUN fully restarts the sequence.
- Simultaneous press event and cfg change in the same cycle: a single transition to HOLD. o_cfg_changed still pulses.
- Counter widths are $clog2 of the respective parameter with a minimum of 1. No counter overflows; all counters saturate or wrap exactly as stated.

Test Plan:
(Parameters used for all scenarios: DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=4, DIV_NORMAL=8, DIV_TURBO=4.)
- Power-up: i_reset for 3 cycles, i_cfg_sw=8'h0F held -> o_cfg_sw=8'h0F with o_cfg_changed never pulsing. o_reset_n goes high 4 cycles after SETTLE exits. After that, o_cpu_ce pulses every 4 cycles (bit 3 = 1, turbo).
- Glitch rejection: in RUN, flip bit 0 for 5 cycles -> o_cfg_sw stays 8'h0F, o_reset_n stays 1, and no o_cfg_changed pulse.
- Accepted change: in RUN, set i_cfg_sw=8'h07 stably -> o_cfg_changed pulses once and o_cfg_sw=8'h07. o_reset_n is low for exactly 4 cycles. o_cpu_ce period becomes 8, starting after the current period completes.
- Masked change: RESET_MASK=8'h01, change bit 7 -> o_cfg_sw updates and o_cfg_changed pulses, but o_reset_n stays 1.
- Button: press for 20 cycles in RUN -> one HOLD of 4 cycles. A second press during HOLD restarts it, so the total low time is measured from the last edge.
- Mid-operation reset: assert i_reset during RUN -> next cycle all outputs are 0 and the FSM re-enters SETTLE.
